// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Holds port ids, lane-enable encodings and the response-register record.
package dmem_arb_pkg;

  localparam logic       PORT_CPU   = 1'b0;
  localparam logic       PORT_DBG   = 1'b1;
  localparam int         ADDR_W_DEF = 10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
    logic err;
  } rsp_t;

  // Any set bit above the word-index field marks the access as out of range.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 32'd2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arb_rsp.sv
// One-entry response register plus steering of rvalid/rdata/err to the
// port that was granted in the previous cycle.
module dmem_arb_rsp
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_i,
  input  logic        port_i,
  input  logic        we_i,
  input  logic        oor_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o
);

  rsp_t        rsp_d;
  rsp_t        rsp_q;
  logic [31:0] data_s;

  // Capture the response owed for this cycle's grant; an in-range write owes none.
  always_comb begin
    rsp_d = '0;
    if (issue_i) begin
      rsp_d.valid   = oor_i | ~we_i;
      rsp_d.port    = port_i;
      rsp_d.is_read = ~we_i;
      rsp_d.err     = oor_i;
    end else begin
      rsp_d = '0;
    end
  end

  // Response register; reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Steer the response to its port; everything reads as zero outside rvalid.
  always_comb begin
    rvalid0_o = 1'b0;
    rvalid1_o = 1'b0;
    rdata0_o  = 32'd0;
    rdata1_o  = 32'd0;
    err0_o    = 1'b0;
    err1_o    = 1'b0;
    data_s    = (rsp_q.is_read && !rsp_q.err) ? mem_rdata_i : 32'd0;
    if (rsp_q.valid && !rst) begin
      if (rsp_q.port == PORT_DBG) begin
        rvalid1_o = 1'b1;
        rdata1_o  = data_s;
        err1_o    = rsp_q.err;
      end else begin
        rvalid0_o = 1'b1;
        rdata0_o  = data_s;
        err0_o    = rsp_q.err;
      end
    end else begin
      rvalid0_o = 1'b0;
      rvalid1_o = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority, the debug port is
// guaranteed a slot after STARVE_MAX consecutive CPU wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [3:0]        be0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [3:0]        be1,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              err0,
  output logic              err1,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_d;
  logic [CW-1:0] starve_q;
  logic          starved_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          issue_s;
  logic          sel_port_s;
  logic          sel_we_s;
  logic          sel_oor_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic [3:0]    sel_be_s;

  assign starved_s = (starve_q == CW'(STARVE_MAX));

  // Fixed priority to the CPU, overridden once the debug port has waited long enough.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      gnt0_s = ~starved_s;
      gnt1_s = starved_s;
    end else if (req0) begin
      gnt0_s = 1'b1;
    end else if (req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Count CPU wins while debug waits; saturation is defensive since the limit forces a debug grant.
  always_comb begin
    starve_d = starve_q;
    if (gnt1_s || !req1) begin
      starve_d = '0;
    end else if (gnt0_s && !starved_s) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Select the granted port's access fields.
  always_comb begin
    issue_s     = gnt0_s | gnt1_s;
    sel_port_s  = gnt1_s ? PORT_DBG : PORT_CPU;
    sel_we_s    = gnt1_s ? we1 : we0;
    sel_addr_s  = gnt1_s ? addr1 : addr0;
    sel_be_s    = gnt1_s ? be1 : be0;
    sel_wdata_s = gnt1_s ? wdata1 : wdata0;
    sel_oor_s   = addr_oor(sel_addr_s, ADDR_W);
  end

  // Drive the memory only for in-range grants; out-of-range grants leave it idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (issue_s && !sel_oor_s) begin
      mem_en    = 1'b1;
      mem_we    = sel_we_s;
      mem_addr  = ADDR_W'(sel_addr_s >> 2);
      mem_be    = sel_be_s;
      mem_wdata = sel_wdata_s;
    end else begin
      mem_en    = 1'b0;
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign cpu_stall = req0 & ~gnt0_s;

  dmem_arb_rsp u_rsp (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (issue_s),
    .port_i      (sel_port_s),
    .we_i        (sel_we_s),
    .oor_i       (sel_oor_s),
    .mem_rdata_i (mem_rdata),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1),
    .rdata0_o    (rdata0),
    .rdata1_o    (rdata1),
    .err0_o      (err0),
    .err1_o      (err1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic, all
// checked against a cycle-level reference model with its own memory image.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [31:0]   addr0, wdata0, addr1, wdata1;
  logic [3:0]    be0, be1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, cpu_stall;
  logic [31:0]   rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  logic [31:0]   tb_mem  [0:(1<<AW)-1] = '{default: 32'd0};
  logic [31:0]   ref_mem [0:(1<<AW)-1] = '{default: 32'd0};

  int            n_total = 0;
  int            n_bad   = 0;
  int            starve  = 0;
  logic          pend_v  = 1'b0;
  logic          pend_p  = 1'b0;
  logic          pend_e  = 1'b0;
  logic [31:0]   pend_d  = 32'd0;
  logic          last_g0 = 1'b0;
  logic          last_g1 = 1'b0;

  logic          s_gnt0, s_gnt1, s_stall, s_en, s_we, s_rv0, s_rv1, s_err1;
  logic [31:0]   s_addr, s_wdata, s_rd0, s_rd1;
  logic [3:0]    s_be;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) tb_mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare against the model at the falling edge, then advance the model.
  task automatic step();
    logic        g0, g1, oor, en, swe;
    logic [31:0] sa, sd;
    logic [3:0]  sb;
    int          w;
    @(negedge clk);
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_stall = cpu_stall; s_en = mem_en; s_we = mem_we;
    s_addr = 32'(mem_addr); s_be = mem_be; s_wdata = mem_wdata;
    s_rv0 = rvalid0; s_rv1 = rvalid1; s_rd0 = rdata0; s_rd1 = rdata1; s_err1 = err1;

    chk("rvalid0", 32'(rvalid0), 32'(!rst && pend_v && !pend_p));
    chk("rvalid1", 32'(rvalid1), 32'(!rst && pend_v && pend_p));
    chk("rdata0", rdata0, (!rst && pend_v && !pend_p) ? pend_d : 32'd0);
    chk("rdata1", rdata1, (!rst && pend_v && pend_p) ? pend_d : 32'd0);
    chk("err0", 32'(err0), 32'(!rst && pend_v && !pend_p && pend_e));
    chk("err1", 32'(err1), 32'(!rst && pend_v && pend_p && pend_e));

    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (req1 && (!req0 || starve == SM)) g1 = 1'b1;
      else if (req0) g0 = 1'b1;
    end
    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    chk("cpu_stall", 32'(cpu_stall), 32'(req0 && !g0));

    sa  = g1 ? addr1 : addr0;
    sd  = g1 ? wdata1 : wdata0;
    sb  = g1 ? be1 : be0;
    swe = g1 ? we1 : we0;
    oor = (sa / 32'(4 << AW)) != 32'd0;
    en  = (g0 || g1) && !oor;
    w   = int'((sa / 32'd4) % 32'(1 << AW));
    chk("mem_en", 32'(mem_en), 32'(en));
    chk("mem_we", 32'(mem_we), en ? 32'(swe) : 32'd0);
    chk("mem_addr", 32'(mem_addr), en ? 32'(w) : 32'd0);
    chk("mem_be", 32'(mem_be), en ? 32'(sb) : 32'd0);
    chk("mem_wdata", mem_wdata, en ? sd : 32'd0);

    if (rst) begin
      starve = 0;
      pend_v = 1'b0;
    end else begin
      pend_v = (g0 || g1) && (oor || !swe);
      pend_p = g1;
      pend_e = oor;
      pend_d = (oor || swe) ? 32'd0 : ref_mem[w];
      if (en && swe)
        for (int k = 0; k < 4; k++)
          if (sb[k]) ref_mem[w][8*k +: 8] = sd[8*k +: 8];
      if (g1 || !req1) starve = 0;
      else if (g0 && starve < SM) starve++;
    end
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic gen(output logic r, output logic we, output logic [31:0] a,
                     output logic [3:0] b, output logic [31:0] d);
    logic [3:0] be_tab [0:6];
    be_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    r  = ($urandom_range(0, 3) != 0);
    we = $urandom_range(0, 1) == 1;
    if ($urandom_range(0, 7) == 0) a = $urandom | (32'd1 << $urandom_range(AW + 2, 31));
    else a = 32'($urandom_range(0, (4 << AW) - 1));
    b = be_tab[$urandom_range(0, 6)];
    d = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; be0 = 4'b0000; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; be1 = 4'b0000; wdata1 = 32'd0;
    #1;
    step();
    req0 = 1'b1;
    step();
    chk("rst stall follows req0", 32'(s_stall), 32'd1);
    chk("rst gnt0", 32'(s_gnt0), 32'd0);
    rst = 1'b0; req0 = 1'b0;
    step();

    // Store word then load it back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; be0 = 4'b1111; wdata0 = 32'h12345678;
    step();
    chk("sw gnt0", 32'(s_gnt0), 32'd1);
    chk("sw mem_addr", s_addr, 32'd2);
    chk("sw mem_we", 32'(s_we), 32'd1);
    chk("sw mem_be", 32'(s_be), 32'hF);
    chk("sw stall", 32'(s_stall), 32'd0);
    we0 = 1'b0;
    step();
    chk("lw gnt0", 32'(s_gnt0), 32'd1);
    req0 = 1'b0;
    step();
    chk("lw rvalid0", 32'(s_rv0), 32'd1);
    chk("lw rdata0", s_rd0, 32'h12345678);
    chk("lw rvalid1", 32'(s_rv1), 32'd0);

    // Continuous contention: four CPU grants then one debug grant.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20; be1 = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("starve gnt1", 32'(s_gnt1), 32'((i % 5) == 4));
      chk("starve stall", 32'(s_stall), 32'((i % 5) == 4));
    end

    // Byte store to a misaligned address.
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h2; be0 = 4'b0100; wdata0 = 32'h00AB0000;
    step();
    chk("sb mem_addr", s_addr, 32'd0);
    chk("sb mem_be", 32'(s_be), 32'h4);
    chk("sb mem_wdata", s_wdata, 32'h00AB0000);

    // Out-of-range debug load.
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h00001000;
    step();
    chk("oor gnt1", 32'(s_gnt1), 32'd1);
    chk("oor mem_en", 32'(s_en), 32'd0);
    req1 = 1'b0;
    step();
    chk("oor rvalid1", 32'(s_rv1), 32'd1);
    chk("oor err1", 32'(s_err1), 32'd1);
    chk("oor rdata1", s_rd1, 32'd0);

    // Read in flight when reset hits must never complete.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    step();
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("rst-flush rvalid0", 32'(s_rv0), 32'd0);
    step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    step();
    chk("post-rst gnt0", 32'(s_gnt0), 32'd1);
    chk("post-rst rvalid0", 32'(s_rv0), 32'd0);

    // Randomized traffic; requesters hold their fields until granted.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (last_g0 || !req0) gen(req0, we0, addr0, be0, wdata0);
      if (last_g1 || !req1) gen(req1, we1, addr1, be1, wdata1);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
